// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline. It detects load-use hazards,
// applies branch/jump flushes and freezes the pipe on slow data memory.
// Memory waits are bounded: a wait that runs too long locks the block in
// ERROR until reset.

module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        use_rs_ID,
  input  logic        use_rt_ID,
  input  logic        MemRead_ID_EX,
  input  logic [4:0]  wr_reg_ID_EX,
  input  logic        jump_ID,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        ID_EX_write,
  output logic        EX_MEM_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        MEM_WB_bubble,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_e;

  // A wait whose incremented count reaches 255 gives up, so the pipe is
  // frozen for 255 cycles in total (the RUN cycle plus 254 MEM_WAIT cycles).
  localparam logic [7:0] WAIT_LAST = 8'd254;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_stall;
  logic freeze;
  logic lu_stall;

  // Hazard detection: r0 is hard-wired zero, so a load into it never blocks.
  always_comb begin
    load_use = MemRead_ID_EX && (wr_reg_ID_EX != 5'd0) &&
               ((use_rs_ID && (rs_ID == wr_reg_ID_EX)) ||
                (use_rt_ID && (rt_ID == wr_reg_ID_EX)));
    mem_stall = mem_req_MEM && !mem_ready;
  end

  // Pipeline control: freeze beats branch flush beats load-use beats jump.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    EX_MEM_write  = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;
    lu_stall      = 1'b0;

    unique case (state_q)
      ST_RUN:      freeze = mem_stall;
      ST_MEM_WAIT: freeze = !mem_ready;
      default:     freeze = 1'b1;  // ERROR and the illegal encoding
    endcase

    if (freeze) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (branch_taken_EX) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, insert one bubble into EX; the jump in ID is
      // retried next cycle, so its flush is suppressed here.
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      lu_stall    = 1'b1;
    end else if (jump_ID) begin
      IF_ID_flush = 1'b1;
    end
  end

  // Next-state logic for the memory-wait FSM and the performance counters.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_ERROR;  // ERROR is terminal; 11 collapses into it
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((freeze || lu_stall) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;

    flush_cnt_d = flush_cnt_q;
    if (IF_ID_flush && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // State, wait counter and performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Each cycle the expected
// control vector, state and counters are predicted by a behavioural model,
// queued, then popped and compared once the DUT outputs have settled.

module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_ID, rt_ID;
  logic        use_rs_ID, use_rt_ID;
  logic        MemRead_ID_EX;
  logic [4:0]  wr_reg_ID_EX;
  logic        jump_ID, branch_taken_EX, mem_req_MEM, mem_ready;
  logic        PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_bubble;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
    .MemRead_ID_EX(MemRead_ID_EX), .wr_reg_ID_EX(wr_reg_ID_EX),
    .jump_ID(jump_ID), .branch_taken_EX(branch_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .MEM_WB_bubble(MEM_WB_bubble),
    .state(state), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_flush, MEM_WB_bubble}
  localparam logic [6:0] CTL_DEFAULT = 7'b1111_000;
  localparam logic [6:0] CTL_FREEZE  = 7'b0000_001;
  localparam logic [6:0] CTL_BRANCH  = 7'b1111_110;
  localparam logic [6:0] CTL_LU      = 7'b0011_010;
  localparam logic [6:0] CTL_JUMP    = 7'b1111_100;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic        tmo;
    logic [15:0] stc;
    logic [15:0] flc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [1:0]  m_state;
  int          m_wc;
  logic        m_to;
  logic [15:0] m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [6:0] dut_ctl();
    return {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
            IF_ID_flush, ID_EX_flush, MEM_WB_bubble};
  endfunction

  task automatic drive_idle();
    rs_ID = 5'd0; rt_ID = 5'd0; use_rs_ID = 1'b0; use_rt_ID = 1'b0;
    MemRead_ID_EX = 1'b0; wr_reg_ID_EX = 5'd0; jump_ID = 1'b0;
    branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 2'b00; m_wc = 0; m_to = 1'b0; m_stall = 16'd0; m_flush = 16'd0;
  endtask

  // One clock cycle: drive, predict+push, settle, pop+compare, advance model.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic mr,
                      input logic [4:0] wr, input logic jmp, input logic br,
                      input logic mreq, input logic mrdy);
    exp_t e, got;
    logic frozen, lu, lus, ifl;
    @(negedge clk);
    rs_ID = rs; rt_ID = rt; use_rs_ID = urs; use_rt_ID = urt;
    MemRead_ID_EX = mr; wr_reg_ID_EX = wr; jump_ID = jmp;
    branch_taken_EX = br; mem_req_MEM = mreq; mem_ready = mrdy;

    lu = mr && (wr != 5'd0) && ((urs && rs == wr) || (urt && rt == wr));
    frozen = (m_state == 2'b10) || (m_state == 2'b11) ||
             (m_state == 2'b00 && mreq && !mrdy) ||
             (m_state == 2'b01 && !mrdy);
    lus = 1'b0;
    if (frozen)   e.ctl = CTL_FREEZE;
    else if (br)  e.ctl = CTL_BRANCH;
    else if (lu)  begin e.ctl = CTL_LU; lus = 1'b1; end
    else if (jmp) e.ctl = CTL_JUMP;
    else          e.ctl = CTL_DEFAULT;
    ifl = e.ctl[2];
    e.st = m_state; e.tmo = m_to; e.stc = m_stall; e.flc = m_flush;
    sb_q.push_back(e);

    #1;
    got = '{ctl: dut_ctl(), st: state, tmo: mem_timeout, stc: stall_cnt, flc: flush_cnt};
    e = sb_q.pop_front();
    check("ctl",   {25'd0, got.ctl}, {25'd0, e.ctl});
    check("state", {30'd0, got.st},  {30'd0, e.st});
    check("tmo",   {31'd0, got.tmo}, {31'd0, e.tmo});
    check("stall", {16'd0, got.stc}, {16'd0, e.stc});
    check("flush", {16'd0, got.flc}, {16'd0, e.flc});

    // Effect of the coming rising edge
    if ((frozen || lus) && m_stall != 16'hFFFF) m_stall++;
    if (ifl && m_flush != 16'hFFFF) m_flush++;
    case (m_state)
      2'b00: if (mreq && !mrdy) begin m_state = 2'b01; m_wc = 1; end
      2'b01: begin
        if (mrdy) begin m_state = 2'b00; m_wc = 0; end
        else begin
          m_wc++;
          if (m_wc == 255) begin m_state = 2'b10; m_to = 1'b1; end
        end
      end
      default: m_state = 2'b10;
    endcase
  endtask

  task automatic idle_step();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Assert reset for one cycle; outputs must show the reset state at once.
  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_ctl",   {25'd0, dut_ctl()}, {25'd0, CTL_DEFAULT});
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_tmo",   {31'd0, mem_timeout}, 32'd0);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    check("rst_flush", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int first_err;

  initial begin
    drive_idle();
    reset = 1'b0;
    model_reset();
    #2;
    apply_reset();

    // Load-use on rs: one bubble, then normal flow
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("lu_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    // Load-use plus taken branch: branch flush wins
    apply_reset();
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_step();
    check("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    check("br_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Jump with load-use stalls only; the repeated jump then flushes
    apply_reset();
    step(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_step();
    check("jmp_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    check("jmp_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Load into r0 never stalls, nor does an unused matching field
    apply_reset();
    step(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    check("r0_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Three-cycle memory wait
    apply_reset();
    for (int i = 0; i < 3; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();
    check("mw_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    check("mw_state", {30'd0, state}, 32'd0);

    // Reset in the middle of a wait leaves no residual freeze
    for (int i = 0; i < 3; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_reset();
    idle_step();
    check("mwrst_ctl", {25'd0, dut_ctl()}, {25'd0, CTL_DEFAULT});

    // Memory timeout after 255 frozen cycles, then sticky ERROR
    first_err = -1;
    for (int i = 0; i < 300; i++) begin
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (state == 2'b10 && first_err < 0) first_err = i;
    end
    check("to_first_err", first_err, 32'd255);
    check("to_state", {30'd0, state}, 32'd2);
    check("to_flag", {31'd0, mem_timeout}, 32'd1);
    for (int i = 0; i < 4; i++) idle_step();  // ready does not leave ERROR
    check("to_sticky", {31'd0, mem_timeout}, 32'd1);
    apply_reset();
    idle_step();

    // Randomised traffic with a mostly-ready memory
    for (int i = 0; i < 250; i++)
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

    // Stall counter saturation
    apply_reset();
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.stall_cnt_q;
    m_stall = 16'hFFFD;
    for (int i = 0; i < 5; i++)
      step(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    check("sat_stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
